// File: rtl/calc_sequencer_if.sv
// Bundles the operator inputs, the ALU response and the sequencer's ALU/display drive.
interface calc_sequencer_if;
    logic [3:0] sw;
    logic [1:0] op_sel;
    logic       btn_enter;
    logic       clear;
    logic [7:0] result;
    logic       done;
    logic       negative;
    logic       div_by_zero;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] op_code;
    logic [1:0] compute_op;
    logic [7:0] disp_value;
    logic       disp_neg;
    logic       err;
    logic       busy;

    modport master (
        input  sw, op_sel, btn_enter, clear, result, done, negative, div_by_zero,
        output A, B, op_code, compute_op, disp_value, disp_neg, err, busy
    );

    modport slave (
        output sw, op_sel, btn_enter, clear, result, done, negative, div_by_zero,
        input  A, B, op_code, compute_op, disp_value, disp_neg, err, busy
    );
endinterface

// File: rtl/calc_sequencer.sv
// Operand/operation entry sequencer for a 4-bit calculator ALU with registered drive and display.
module calc_sequencer #(
    parameter int DONE_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    calc_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    localparam logic [2:0] OP_NOOP    = 3'b000;
    localparam logic [2:0] OP_SHOW_A  = 3'b010;
    localparam logic [2:0] OP_SHOW_B  = 3'b100;
    localparam logic [2:0] OP_COMPUTE = 3'b101;
    localparam logic [2:0] OP_SHOW_R  = 3'b110;

    typedef enum logic [2:0] {
        GET_A, SHOW_A, SHOW_B, WAIT_DONE, SHOW_RES, ERR
    } state_t;

    state_t           state, next_state;
    logic             btn_q;
    logic             press;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [1:0]       cop_q, cop_d;
    logic [2:0]       opc_q, opc_d;
    logic [7:0]       disp_q, disp_d;
    logic             dneg_q, dneg_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    assign press = bus.btn_enter & ~btn_q;

    // State and every output are registered together so outputs track the state just entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= GET_A;
            btn_q  <= 1'b0;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cop_q  <= '0;
            opc_q  <= OP_NOOP;
            disp_q <= '0;
            dneg_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= next_state;
            btn_q  <= bus.btn_enter;
            cnt    <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cop_q  <= cop_d;
            opc_q  <= opc_d;
            disp_q <= disp_d;
            dneg_q <= dneg_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.clear) begin
            next_state = GET_A;
        end else begin
            case (state)
                GET_A:     if (press) next_state = SHOW_A;
                SHOW_A:    if (press) next_state = SHOW_B;
                SHOW_B:    if (press) next_state = WAIT_DONE;
                WAIT_DONE: begin
                    // A completing ALU beats the timeout on the same cycle.
                    if (bus.done)
                        next_state = bus.div_by_zero ? ERR : SHOW_RES;
                    else if (cnt == TIMEOUT_LAST)
                        next_state = ERR;
                end
                SHOW_RES:  if (press) next_state = GET_A;
                ERR:       if (press) next_state = GET_A;
                default:   next_state = GET_A;
            endcase
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        cop_d  = cop_q;
        cnt_d  = cnt;
        opc_d  = OP_NOOP;
        disp_d = disp_q;
        dneg_d = dneg_q;
        err_d  = 1'b0;
        busy_d = 1'b0;

        if (!bus.clear) begin
            case (state)
                GET_A:     if (press) a_d = bus.sw;
                SHOW_A:    if (press) b_d = bus.sw;
                SHOW_B: begin
                    if (press) begin
                        cop_d = bus.op_sel;
                        cnt_d = '0;
                    end
                end
                WAIT_DONE: if (!bus.done && cnt != TIMEOUT_LAST) cnt_d = cnt + 1'b1;
                default:   ;
            endcase
        end

        case (next_state)
            GET_A: begin
                disp_d = '0;
                dneg_d = 1'b0;
            end
            SHOW_A: begin
                opc_d  = OP_SHOW_A;
                disp_d = {4'b0, a_d};
                dneg_d = 1'b0;
            end
            SHOW_B: begin
                opc_d  = OP_SHOW_B;
                disp_d = {4'b0, b_d};
                dneg_d = 1'b0;
            end
            WAIT_DONE: begin
                opc_d  = OP_COMPUTE;
                busy_d = 1'b1;
            end
            SHOW_RES: begin
                opc_d = OP_SHOW_R;
                if (state == WAIT_DONE) begin
                    disp_d = bus.result;
                    dneg_d = bus.negative;
                end
            end
            ERR: begin
                err_d  = 1'b1;
                disp_d = 8'hEE;
                dneg_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.compute_op = cop_q;
    assign bus.op_code    = opc_q;
    assign bus.disp_value = disp_q;
    assign bus.disp_neg   = dneg_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed-plus-random bench for calc_sequencer with a behavioural ALU and display model.
module tb_calc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;

    calc_sequencer_if bus();

    calc_sequencer #(.DONE_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural ALU: magnitude result with sign flag; divide by zero flagged.
    function automatic void alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                                output logic [7:0] res, output logic neg, output logic dz);
        int x;
        neg = 1'b0;
        dz  = 1'b0;
        x   = 0;
        case (op)
            2'd0: x = int'(a) + int'(b);
            2'd1: begin
                x = int'(a) - int'(b);
                if (x < 0) begin
                    neg = 1'b1;
                    x   = -x;
                end
            end
            2'd2: x = int'(a) * int'(b);
            default: if (b == 0) dz = 1'b1; else x = int'(a) / int'(b);
        endcase
        res = 8'(x);
    endfunction

    task automatic press_key(input logic [3:0] value);
        bus.sw        = value;
        bus.btn_enter = 1'b1;
        tick();
        bus.btn_enter = 1'b0;
    endtask

    task automatic enter_operands(input logic [3:0] a, input logic [3:0] b, input string tag);
        press_key(a);
        check({tag, "_opA"}, {5'b0, bus.op_code}, 8'h02);
        check({tag, "_dispA"}, bus.disp_value, {4'b0, a});
        check({tag, "_A"}, {4'b0, bus.A}, {4'b0, a});
        tick();
        press_key(b);
        check({tag, "_opB"}, {5'b0, bus.op_code}, 8'h04);
        check({tag, "_dispB"}, bus.disp_value, {4'b0, b});
        check({tag, "_B"}, {4'b0, bus.B}, {4'b0, b});
        tick();
    endtask

    task automatic calc(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input int lat, input string tag);
        logic [7:0] res;
        logic neg, dz;
        alu(a, b, op, res, neg, dz);
        enter_operands(a, b, tag);
        bus.op_sel = op;
        press_key(4'h0);
        check({tag, "_opC"}, {5'b0, bus.op_code}, 8'h05);
        check({tag, "_busy"}, {7'b0, bus.busy}, 8'h01);
        check({tag, "_cop"}, {6'b0, bus.compute_op}, {6'b0, op});
        for (int i = 0; i < lat; i++) begin
            bus.btn_enter = (i == 0);
            tick();
            check({tag, "_wait"}, {5'b0, bus.op_code}, 8'h05);
        end
        bus.btn_enter   = 1'b0;
        bus.done        = 1'b1;
        bus.result      = res;
        bus.negative    = neg;
        bus.div_by_zero = dz;
        tick();
        bus.done = 1'b0;
        bus.div_by_zero = 1'b0;
        bus.negative = 1'b0;
        if (dz) begin
            check({tag, "_err"}, {7'b0, bus.err}, 8'h01);
            check({tag, "_dispE"}, bus.disp_value, 8'hEE);
            check({tag, "_opE"}, {5'b0, bus.op_code}, 8'h00);
        end else begin
            check({tag, "_opR"}, {5'b0, bus.op_code}, 8'h06);
            check({tag, "_res"}, bus.disp_value, res);
            check({tag, "_neg"}, {7'b0, bus.disp_neg}, {7'b0, neg});
        end
        check({tag, "_idle"}, {7'b0, bus.busy}, 8'h00);
        tick();
        press_key(4'h0);
        check({tag, "_back"}, {5'b0, bus.op_code}, 8'h00);
        check({tag, "_backerr"}, {7'b0, bus.err}, 8'h00);
        check({tag, "_backdisp"}, bus.disp_value, 8'h00);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ra, rb;
        logic [1:0] rop;
        reset = 1'b1;
        bus.sw = '0; bus.op_sel = '0; bus.btn_enter = 1'b0; bus.clear = 1'b0;
        bus.result = '0; bus.done = 1'b0; bus.negative = 1'b0; bus.div_by_zero = 1'b0;
        tick();
        tick();
        check("rst_op", {5'b0, bus.op_code}, 8'h00);
        check("rst_A", {4'b0, bus.A}, 8'h00);
        check("rst_B", {4'b0, bus.B}, 8'h00);
        check("rst_disp", bus.disp_value, 8'h00);
        check("rst_busy", {7'b0, bus.busy}, 8'h00);
        check("rst_err", {7'b0, bus.err}, 8'h00);
        reset = 1'b0;
        tick();

        // done outside WAIT_DONE must be ignored
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("done_ignored", {5'b0, bus.op_code}, 8'h00);

        calc(4'd5, 4'd3, 2'd0, 2, "add");
        calc(4'd3, 4'd5, 2'd1, 1, "sub");
        calc(4'd7, 4'd0, 2'd3, 0, "div0");
        calc(4'd15, 4'd15, 2'd2, 3, "mulmax");

        for (int k = 0; k < 6; k++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 2'($urandom_range(0, 3));
            calc(ra, rb, rop, int'($urandom_range(0, 6)), $sformatf("rnd%0d", k));
        end

        // Held button yields exactly one press
        bus.sw = 4'd9;
        bus.btn_enter = 1'b1;
        tick();
        bus.sw = 4'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("hold_op", {5'b0, bus.op_code}, 8'h02);
            check("hold_A", {4'b0, bus.A}, 8'h09);
        end
        bus.btn_enter = 1'b0;
        tick();

        // Clear from SHOW_B keeps operands and operation
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
        enter_operands(4'd6, 4'd4, "clr");
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clr_op", {5'b0, bus.op_code}, 8'h00);
        check("clr_disp", bus.disp_value, 8'h00);
        check("clr_A", {4'b0, bus.A}, 8'h06);
        check("clr_B", {4'b0, bus.B}, 8'h04);
        check("clr_cop", {6'b0, bus.compute_op}, {6'b0, rop});
        tick();

        // Timeout: busy for exactly DONE_TIMEOUT cycles
        enter_operands(4'd1, 4'd2, "to");
        bus.op_sel = 2'd0;
        press_key(4'h0);
        check("to_busy0", {7'b0, bus.busy}, 8'h01);
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to_busy", {7'b0, bus.busy}, 8'h01);
        end
        tick();
        check("to_err", {7'b0, bus.err}, 8'h01);
        check("to_busyoff", {7'b0, bus.busy}, 8'h00);
        check("to_disp", bus.disp_value, 8'hEE);
        tick();
        press_key(4'h0);
        check("to_clrerr", {7'b0, bus.err}, 8'h00);
        tick();

        // Reset during WAIT_DONE
        enter_operands(4'd8, 4'd3, "rw");
        bus.op_sel = 2'd2;
        press_key(4'h0);
        check("rw_busy", {7'b0, bus.busy}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_op", {5'b0, bus.op_code}, 8'h00);
        check("rw_busy0", {7'b0, bus.busy}, 8'h00);
        check("rw_A", {4'b0, bus.A}, 8'h00);
        check("rw_B", {4'b0, bus.B}, 8'h00);
        check("rw_cop", {6'b0, bus.compute_op}, 8'h00);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
